rf_wb_sched: RTL and testbench

- Write-port scheduler and scoreboard for the 32x32 register file. It shares the file's single write port between two writeback sources:
  - the single-cycle fast path (ALU/imm/PC+4 result already muxed);
  - a long-latency slow path (data memory / multi-cycle unit) that returns out of band.
- Tracks registers with outstanding slow writebacks and stalls issue on RAW/WAW hazards.
- Sits between decode/issue and the register file write inputs (we, wR, write data).

---
 rtl/rf_wb_sched.sv | 193 +++++++++++++++++++
 tb/tb_rf_wb_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_sched.sv
// Write-port scheduler and scoreboard for the 32x32 register file.
// It shares the single write port between the fast writeback path and a
// buffered slow-return path, and stalls issue on RAW/WAW hazards against
// outstanding slow writes.
module rf_wb_sched #(
    parameter int SLOW_DEPTH   = 4,
    parameter int MAX_PENDING  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic        issue_use1,
    input  logic        issue_use2,
    input  logic        issue_we,
    input  logic [4:0]  issue_rd,
    input  logic        issue_long,
    output logic        issue_stall,
    input  logic        fast_valid,
    input  logic [4:0]  fast_rd,
    input  logic [31:0] fast_data,
    input  logic        slow_valid,
    input  logic [4:0]  slow_rd,
    input  logic [31:0] slow_data,
    output logic        slow_ready,
    output logic        rf_we,
    output logic [4:0]  rf_wr,
    output logic [31:0] rf_wd,
    output logic [31:0] busy_mask,
    output logic        proto_err
);

    localparam int PTR_W = $clog2(SLOW_DEPTH);
    localparam int CNT_W = $clog2(SLOW_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FIFO_MAX   = CNT_W'(SLOW_DEPTH);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);
    localparam logic [5:0]       PEND_MAX   = 6'(MAX_PENDING);

    // Slow-return buffer storage and control.
    logic [4:0]       fifo_rd   [SLOW_DEPTH];
    logic [31:0]      fifo_data [SLOW_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [4:0]       head_rd;
    logic [31:0]      head_data;

    // Arbitration, scoreboard and starvation state.
    logic             fast_go;
    logic             issue_accept;
    logic             busy_set;
    logic [31:0]      busy_next;
    logic [5:0]       pending_count;
    logic [STV_W-1:0] starve_cnt;
    logic             throttle;

    assign fifo_full  = (fifo_cnt == FIFO_MAX);
    assign fifo_empty = (fifo_cnt == '0);
    assign slow_ready = !fifo_full;
    assign push       = slow_valid && slow_ready;
    assign head_rd    = fifo_rd[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];

    // A fast write to x0 is dropped, so it does not claim the port.
    assign fast_go = fast_valid && (fast_rd != 5'd0);
    assign pop     = !fast_go && !fifo_empty;

    // Count outstanding slow writebacks from the registered scoreboard.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pending_count = '0;
        for (int i = 0; i < 32; i++) begin
            pending_count = pending_count + 6'(busy_mask[i]);
        end
    end

    // Hazard stall is purely from registered state: a clear in this cycle is not bypassed.
    always_comb begin
        issue_stall = 1'b0;
        if (issue_valid) begin
            if ((issue_use1 && busy_mask[issue_rs1]) ||
                (issue_use2 && busy_mask[issue_rs2]) ||
                (issue_we   && busy_mask[issue_rd])  ||
                (issue_long && issue_we && (pending_count == PEND_MAX)) ||
                throttle) begin
                issue_stall = 1'b1;
            end
        end
    end

    assign issue_accept = issue_valid && !issue_stall;
    assign busy_set     = issue_accept && issue_long && issue_we && (issue_rd != 5'd0);

    // Next scoreboard: clear the committing slow destination, then mark a new long op.
    always_comb begin
        busy_next = busy_mask;
        if (pop && (head_rd != 5'd0)) begin
            busy_next[head_rd] = 1'b0;
        end
        if (busy_set) begin
            busy_next[issue_rd] = 1'b1;
        end
    end

    // Buffer payload write; contents are only ever read behind a valid count.
    // NOTE: storage arrays are deliberately left out of reset; the count and pointers guard them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= slow_rd;
            fifo_data[wr_ptr] <= slow_data;
        end
    end

    // Buffer pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
        end
    end

    // Registered write port: fast wins, otherwise the buffer head; index/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_wr <= '0;
            rf_wd <= '0;
        end else if (fast_go) begin
            rf_we <= 1'b1;
            rf_wr <= fast_rd;
            rf_wd <= fast_data;
        end else if (pop && (head_rd != 5'd0)) begin
            rf_we <= 1'b1;
            rf_wr <= head_rd;
            rf_wd <= head_data;
        end else begin
            rf_we <= 1'b0;
        end
    end

    // Scoreboard update and sticky flag for a slow return nobody was waiting on.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_mask <= '0;
            proto_err <= 1'b0;
        end else begin
            busy_mask <= busy_next;
            if (pop && (head_rd != 5'd0) && !busy_mask[head_rd]) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Starvation counter: counts lost arbitration cycles of a waiting head, throttles issue at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            throttle   <= 1'b0;
        end else if (pop) begin
            starve_cnt <= '0;
            throttle   <= 1'b0;
        end else if (!fifo_empty && fast_go) begin
            if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            if (starve_cnt >= STARVE_MAX - 1'b1) begin
                throttle <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed bench for rf_wb_sched: reset, long-op RAW/WAW stall, arbitration,
// MAX_PENDING and full-buffer behaviour, starvation throttle, x0 handling and
// the sticky protocol error.
module tb_rf_wb_sched;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_use1;
    logic        issue_use2;
    logic        issue_we;
    logic [4:0]  issue_rd;
    logic        issue_long;
    logic        issue_stall;
    logic        fast_valid;
    logic [4:0]  fast_rd;
    logic [31:0] fast_data;
    logic        slow_valid;
    logic [4:0]  slow_rd;
    logic [31:0] slow_data;
    logic        slow_ready;
    logic        rf_we;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wd;
    logic [31:0] busy_mask;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    rf_wb_sched #(
        .SLOW_DEPTH  (4),
        .MAX_PENDING (4),
        .STARVE_LIMIT(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_rs1  (issue_rs1),
        .issue_rs2  (issue_rs2),
        .issue_use1 (issue_use1),
        .issue_use2 (issue_use2),
        .issue_we   (issue_we),
        .issue_rd   (issue_rd),
        .issue_long (issue_long),
        .issue_stall(issue_stall),
        .fast_valid (fast_valid),
        .fast_rd    (fast_rd),
        .fast_data  (fast_data),
        .slow_valid (slow_valid),
        .slow_rd    (slow_rd),
        .slow_data  (slow_data),
        .slow_ready (slow_ready),
        .rf_we      (rf_we),
        .rf_wr      (rf_wr),
        .rf_wd      (rf_wd),
        .busy_mask  (busy_mask),
        .proto_err  (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0;
        issue_use1  = 1'b0; issue_use2 = 1'b0; issue_we = 1'b0;
        issue_rd    = '0;   issue_long = 1'b0;
        fast_valid  = 1'b0; fast_rd = '0; fast_data = '0;
        slow_valid  = 1'b0; slow_rd = '0; slow_data = '0;
    endtask

    task automatic issue_long_op(input logic [4:0] rd);
        idle();
        issue_valid = 1'b1; issue_we = 1'b1; issue_long = 1'b1; issue_rd = rd;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_rf_we", 32'(rf_we), 32'd0);
        check("reset_rf_wr", 32'(rf_wr), 32'd0);
        check("reset_rf_wd", rf_wd, 32'd0);
        check("reset_busy", busy_mask, 32'd0);
        check("reset_ready", 32'(slow_ready), 32'd1);
        check("reset_proto", 32'(proto_err), 32'd0);

        // ---------------- Long-op RAW on x5 ----------------
        issue_long_op(5'd5);
        settle();
        check("raw_long_accept", 32'(issue_stall), 32'd0);
        tick();
        idle();
        check("raw_busy_set", busy_mask, 32'h0000_0020);
        issue_valid = 1'b1; issue_use1 = 1'b1; issue_rs1 = 5'd5;
        settle();
        check("raw_stall_rs1", 32'(issue_stall), 32'd1);
        issue_use1 = 1'b0; issue_use2 = 1'b1; issue_rs2 = 5'd5;
        settle();
        check("raw_stall_rs2", 32'(issue_stall), 32'd1);
        issue_use2 = 1'b0; issue_we = 1'b1; issue_rd = 5'd5;
        settle();
        check("waw_stall_rd", 32'(issue_stall), 32'd1);
        issue_we = 1'b0; issue_rd = 5'd0; issue_use1 = 1'b1;
        slow_valid = 1'b1; slow_rd = 5'd5; slow_data = 32'hDEAD_BEEF;
        tick();
        slow_valid = 1'b0;
        check("raw_buffered_no_we", 32'(rf_we), 32'd0);
        check("raw_still_stalled", 32'(issue_stall), 32'd1);
        tick();
        check("raw_slow_we", 32'(rf_we), 32'd1);
        check("raw_slow_wr", 32'(rf_wr), 32'd5);
        check("raw_slow_wd", rf_wd, 32'hDEAD_BEEF);
        check("raw_busy_clear", busy_mask, 32'd0);
        check("raw_dep_accept", 32'(issue_stall), 32'd0);
        tick();
        idle();
        check("idle_no_we", 32'(rf_we), 32'd0);
        check("idle_hold_wr", 32'(rf_wr), 32'd5);
        check("idle_hold_wd", rf_wd, 32'hDEAD_BEEF);

        // ---------------- Arbitration fast vs slow ----------------
        issue_long_op(5'd7);
        tick();
        idle();
        check("arb_busy7", busy_mask, 32'h0000_0080);
        fast_valid = 1'b1; fast_rd = 5'd3; fast_data = 32'h11;
        slow_valid = 1'b1; slow_rd = 5'd7; slow_data = 32'h22;
        tick();
        idle();
        check("arb_fast_wr", 32'(rf_wr), 32'd3);
        check("arb_fast_wd", rf_wd, 32'h11);
        tick();
        check("arb_slow_we", 32'(rf_we), 32'd1);
        check("arb_slow_wr", 32'(rf_wr), 32'd7);
        check("arb_slow_wd", rf_wd, 32'h22);
        check("arb_proto", 32'(proto_err), 32'd0);
        check("arb_busy_clear", busy_mask, 32'd0);

        // ---------------- MAX_PENDING and full buffer ----------------
        for (int r = 1; r <= 4; r++) begin
            issue_long_op(5'(r));
            settle();
            check("pend_accept", 32'(issue_stall), 32'd0);
            tick();
        end
        idle();
        check("pend_busy", busy_mask, 32'h0000_001E);
        issue_long_op(5'd6);
        settle();
        check("pend_max_stall", 32'(issue_stall), 32'd1);
        issue_long = 1'b0; issue_rd = 5'd10;
        settle();
        check("pend_short_ok", 32'(issue_stall), 32'd0);
        idle();
        for (int r = 1; r <= 4; r++) begin
            fast_valid = 1'b1; fast_rd = 5'd12; fast_data = 32'hF0F0;
            slow_valid = 1'b1; slow_rd = 5'(r); slow_data = 32'h100 + 32'(r);
            settle();
            check("full_ready_before", 32'(slow_ready), 32'd1);
            tick();
        end
        check("full_ready_low", 32'(slow_ready), 32'd0);
        check("full_fast_wr", 32'(rf_wr), 32'd12);
        check("full_fast_wd", rf_wd, 32'hF0F0);
        idle();
        for (int r = 1; r <= 4; r++) begin
            tick();
            check("drain_we", 32'(rf_we), 32'd1);
            check("drain_wr", 32'(rf_wr), 32'(r));
            check("drain_wd", rf_wd, 32'h100 + 32'(r));
        end
        check("drain_busy", busy_mask, 32'd0);
        check("drain_ready", 32'(slow_ready), 32'd1);
        check("drain_proto", 32'(proto_err), 32'd0);

        // ---------------- Starvation throttle ----------------
        issue_long_op(5'd8);
        tick();
        idle();
        fast_valid = 1'b1; fast_rd = 5'd13; fast_data = 32'hAA;
        slow_valid = 1'b1; slow_rd = 5'd8; slow_data = 32'h0808;
        tick();
        slow_valid = 1'b0;
        issue_valid = 1'b1; issue_use1 = 1'b1; issue_rs1 = 5'd2;
        for (int i = 1; i <= 8; i++) begin
            settle();
            check("starve_no_stall", 32'(issue_stall), 32'd0);
            tick();
        end
        check("starve_stall", 32'(issue_stall), 32'd1);
        tick();
        check("starve_stall_hold", 32'(issue_stall), 32'd1);
        check("starve_fast_wr", 32'(rf_wr), 32'd13);
        fast_valid = 1'b0;
        settle();
        check("starve_until_pop", 32'(issue_stall), 32'd1);
        tick();
        check("starve_slow_we", 32'(rf_we), 32'd1);
        check("starve_slow_wr", 32'(rf_wr), 32'd8);
        check("starve_slow_wd", rf_wd, 32'h0808);
        check("starve_released", 32'(issue_stall), 32'd0);
        idle();

        // ---------------- x0 and protocol error ----------------
        fast_valid = 1'b1; fast_rd = 5'd0; fast_data = 32'h55;
        tick();
        idle();
        check("x0_fast_no_we", 32'(rf_we), 32'd0);
        check("x0_fast_hold_wr", 32'(rf_wr), 32'd8);
        issue_long_op(5'd0);
        tick();
        idle();
        check("x0_never_busy", busy_mask, 32'd0);
        slow_valid = 1'b1; slow_rd = 5'd9; slow_data = 32'h99;
        tick();
        idle();
        check("proto_not_yet", 32'(proto_err), 32'd0);
        tick();
        check("proto_we", 32'(rf_we), 32'd1);
        check("proto_wr", 32'(rf_wr), 32'd9);
        check("proto_wd", rf_wd, 32'h99);
        check("proto_set", 32'(proto_err), 32'd1);
        tick();
        tick();
        check("proto_sticky", 32'(proto_err), 32'd1);

        // ---------------- Reset mid-traffic ----------------
        issue_long_op(5'd5);
        tick();
        idle();
        slow_valid = 1'b1; slow_rd = 5'd5; slow_data = 32'h5555;
        tick();
        idle();
        rst = 1'b1;
        fast_valid = 1'b1; fast_rd = 5'd3; fast_data = 32'h33;
        tick();
        tick();
        rst = 1'b0;
        idle();
        check("rst_mid_we", 32'(rf_we), 32'd0);
        check("rst_mid_busy", busy_mask, 32'd0);
        check("rst_mid_ready", 32'(slow_ready), 32'd1);
        check("rst_mid_proto", 32'(proto_err), 32'd0);
        tick();
        check("rst_mid_discard", 32'(rf_we), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
